// File: rtl/irda_dma_ctrl.sv
// Multi-channel DMA request generator for the IrDA FIFOs: per-channel fill/drain triggers, bounded bursts, ack timeout.
// Define IRDA_DMA_FIXED_PRIORITY_EN for lowest-index-first arbitration; the default build is round-robin.
module irda_dma_ctrl #(
  parameter int NCH     = 2,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 5,
  parameter int BURST_W = 4,
  parameter int TMO_W   = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 enable_i,
  input  logic [NCH-1:0]       ch_dir_i,
  input  logic [NCH*CNT_W-1:0] fifo_count_i,
  input  logic [NCH*CNT_W-1:0] trig_level_i,
  input  logic [BURST_W-1:0]   burst_len_i,
  output logic [NCH-1:0]       dma_req_o,
  input  logic [NCH-1:0]       dma_ack_i,
  output logic [NCH-1:0]       xfer_o,
  output logic [NCH-1:0]       timeout_o,
  input  logic [NCH-1:0]       tmo_clr_i,
  output logic                 busy_o
);
  localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((2 ** TMO_W) - 2);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;
  state_t r_state, w_state_nxt;

  logic [SEL_W-1:0] r_ptr, r_sel, w_pick, w_idx;
  logic [CNT_W-1:0] r_beat, r_limit;
  logic [TMO_W-1:0] r_tmo;
  logic [NCH-1:0]   r_timeout, w_tmo_set, w_elig;
  logic [CNT_W-1:0] w_avail [NCH];
  logic [CNT_W-1:0] w_burst_eff, w_avail_pick, w_limit_nxt;
  logic             w_any, w_ack;
`ifndef IRDA_DMA_FIXED_PRIORITY_EN
  logic             w_hit;
`endif

  // avail is words the DMA may move now: stored words (drain) or free slots (fill)
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [CNT_W-1:0] w_cnt, w_trig, w_lvl;
    assign w_cnt      = fifo_count_i[k*CNT_W +: CNT_W];
    assign w_trig     = trig_level_i[k*CNT_W +: CNT_W];
    assign w_lvl      = (w_trig == '0) ? CNT_W'(1) : w_trig;
    assign w_avail[k] = ch_dir_i[k] ? w_cnt : (DEPTH_C - w_cnt);
    assign w_elig[k]  = enable_i && (w_avail[k] >= w_lvl) &&
                        (ch_dir_i[k] ? (w_cnt != '0) : (w_cnt != DEPTH_C));
  end

  always_comb begin
    w_pick = r_ptr;
    w_idx  = '0;
`ifdef IRDA_DMA_FIXED_PRIORITY_EN
    for (int i = NCH - 1; i >= 0; i--) begin
      w_idx = SEL_W'(i);
      if (w_elig[w_idx]) w_pick = w_idx;
    end
`else
    w_hit = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      w_idx = SEL_W'((int'(r_ptr) + i) % NCH);
      if (!w_hit && w_elig[w_idx]) begin
        w_pick = w_idx;
        w_hit  = 1'b1;
      end
    end
`endif
  end

  assign w_any        = |w_elig;
  assign w_burst_eff  = (burst_len_i == '0) ? CNT_W'(1) : CNT_W'(burst_len_i);
  assign w_avail_pick = w_avail[w_pick];
  assign w_limit_nxt  = (w_burst_eff < w_avail_pick) ? w_burst_eff : w_avail_pick;
  assign w_ack        = dma_ack_i[r_sel];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    dma_req_o   = '0;
    xfer_o      = '0;
    w_tmo_set   = '0;
    busy_o      = 1'b0;
    case (r_state)
      S_IDLE: if (w_any) w_state_nxt = S_REQ;
      S_REQ: begin
        busy_o           = 1'b1;
        dma_req_o[r_sel] = 1'b1;
        if (w_ack) begin
          xfer_o[r_sel] = 1'b1;
          if (r_beat + CNT_W'(1) == r_limit) w_state_nxt = S_GAP;
        end else if (enable_i && (r_tmo == TMO_LAST)) begin
          w_tmo_set[r_sel] = 1'b1;
          w_state_nxt      = S_GAP;
        end
        // disabling aborts the burst quietly; acked words are kept
        if (!enable_i) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        busy_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ptr     <= SEL_W'(NCH - 1);
      r_sel     <= '0;
      r_beat    <= '0;
      r_limit   <= '0;
      r_tmo     <= '0;
      r_timeout <= '0;
    end else begin
      r_timeout <= (r_timeout & ~tmo_clr_i) | w_tmo_set;
      if ((r_state == S_IDLE) && w_any) begin
        r_ptr   <= w_pick;
        r_sel   <= w_pick;
        r_limit <= w_limit_nxt;
        r_beat  <= '0;
        r_tmo   <= '0;
      end else if (r_state == S_REQ) begin
        if (w_ack) begin
          r_beat <= r_beat + CNT_W'(1);
          r_tmo  <= '0;
        end else begin
          r_tmo  <= r_tmo + TMO_W'(1);
        end
      end
    end
  end

  assign timeout_o = r_timeout;

endmodule

// File: doc/irda_dma_ctrl.md
Name: irda_dma_ctrl

Overview:
- Parametrised multi-channel DMA request generator for the IrDA core.
- Replaces the single fixed transmit/receive request pair with NCH channels, each of which can be set as fill (TX) or drain (RX).
- Each channel has its own trigger level. Grants are bounded bursts, arbitrated round-robin, with an ack timeout.
- Sits between the FIFO count outputs and the external DMA engine. Its per-word strobes drive the FIFO add/remove inputs.

Parameters:
- NCH, 2, number of DMA channels.
- DEPTH, 16, FIFO depth in words; the same for all channels.
- CNT_W, 5, width of each FIFO count and trigger level; must hold the value DEPTH.
- BURST_W, 4, width of the burst-length field.
- TMO_W, 8, width of the ack-timeout counter.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- enable_i  in  1  global DMA enable (use_dma).
- ch_dir_i  in  NCH  per channel: 1 = drain (RX FIFO), 0 = fill (TX FIFO).
- fifo_count_i  in  NCH*CNT_W  per-channel FIFO occupancy; channel k is at bits [k*CNT_W +: CNT_W].
- trig_level_i  in  NCH*CNT_W  per-channel trigger level in words.
- burst_len_i  in  BURST_W  maximum words per grant; 0 is treated as 1.
- dma_req_o  out  NCH  request, one-hot or zero.
- dma_ack_i  in  NCH  per-word acknowledge from the DMA engine.
- xfer_o  out  NCH  one-cycle strobe per accepted word.
- timeout_o  out  NCH  sticky ack-timeout flag.
- tmo_clr_i  in  NCH  clears timeout_o bits.
- busy_o  out  1  high in REQ and GAP.

Behaviour:
- Reset values: dma_req_o=0, xfer_o=0, timeout_o=0, busy_o=0, state=IDLE, round-robin pointer=NCH-1, beat and timeout counters=0.
- Effective level: lvl = trig_level, or 1 when trig_level is 0.
- Channel k is eligible when enable_i=1 and:
  - drain: count >= lvl and count != 0;
  - fill: (DEPTH - count) >= lvl and count != DEPTH.
- IDLE:
  - If any channel is eligible, select the first eligible channel searching upward from pointer+1, wrapping modulo NCH.
  - Set pointer to the selected channel.
  - Capture limit = min(burst_len_eff, avail), where avail = count (drain) or DEPTH - count (fill). Compare at CNT_W width; zero-extend burst_len.
  - Clear the beat and timeout counters. Go to REQ next cycle.
- REQ:
  - dma_req_o[sel]=1 while in REQ.
  - On each cycle with dma_ack_i[sel]=1: xfer_o[sel]=1 combinationally in the same cycle, beat+1, timeout counter cleared.
  - When the ack brings beat to limit, req drops the next cycle and the state goes to GAP.
  - Otherwise the timeout counter increments each ack-free cycle. At 2^TMO_W-1 ack-free cycles: set timeout_o[sel], drop req, go to GAP.
  - enable_i=0 in REQ: go to GAP next cycle; no timeout flag is set; beats already acked stand.
- GAP: one cycle with all req=0, then IDLE. This gives the FIFO count one cycle to settle before re-evaluation.
- Acks on non-selected channels, or in IDLE/GAP: ignored, no xfer strobe.
- xfer_o: never more than one bit high per cycle; only asserted with a matching ack in REQ.
- The FIFO count is sampled only at grant. Changes during a burst do not extend or shorten it, because the limit already guarantees no overrun or underrun.
- timeout_o[k] set and tmo_clr_i[k] in the same cycle: set wins.
- Reset asserted mid-burst: all outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro IRDA_DMA_FIXED_PRIORITY_EN.
- Defined: arbitration in IDLE is fixed priority, lowest channel index first; the pointer is unused.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
1. NCH=2, ch0 drain, count=8, level=4, burst=4, ack every cycle -> req0 high 4 cycles, 4 xfer0 strobes, 1 GAP cycle, re-grant if still eligible.
2. Both channels eligible continuously, ch1 fill with count=0, level=8 -> grants alternate ch0, ch1, ch0 (round-robin); with IRDA_DMA_FIXED_PRIORITY_EN, ch0 repeatedly.
3. Drain count=2, burst=8 -> limit=2, exactly 2 xfer strobes, req drops after the 2nd ack.
4. No ack for 255 cycles (TMO_W=8) -> req drops, timeout_o[sel]=1 and held; tmo_clr_i pulse clears it; simultaneous set and clear -> stays 1.
5. enable_i deasserted after 1 of 4 beats -> req drops the next cycle, timeout_o stays 0, one xfer strobe total; spurious ack on an unselected channel -> no xfer.
6. wb_rst_i asserted mid-REQ -> dma_req_o, xfer_o, busy_o are 0 without a clock edge; after release, grant order restarts at ch0.
